// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max frame tracker.
// Holds the controller state encoding and the fixed datapath widths.
package minmax_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    CMP_MAX = 3'd2,
    CMP_MIN = 3'd3,
    DONE    = 3'd4
  } state_t;

  // True once the number of accepted samples has reached the frame length.
  function automatic logic frame_complete(input logic [LEN_W-1:0] cnt,
                                          input logic [LEN_W-1:0] len);
    return (cnt == len);
  endfunction

endpackage

// File: rtl/comparator.sv
// 16-bit unsigned magnitude comparator, shared by the max and min update steps.
module comparator
  import minmax_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt,
  output logic        lt,
  output logic        eq
);

  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/minmax_tracker.sv
// Tracks the largest and smallest unsigned sample over a frame, one comparator
// time-shared across a max step and a min step for every sample after the first.
module minmax_tracker
  import minmax_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [7:0]  frame_len,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] max_out,
  output logic [15:0] min_out
);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt_r;
  logic [LEN_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] max_r;
  logic [DATA_W-1:0] min_r;
  logic [DATA_W-1:0] max_nxt;
  logic [DATA_W-1:0] min_nxt;
  logic [DATA_W-1:0] cmp_b;
  logic              cmp_gt;
  logic              cmp_lt;
  logic              cmp_eq;
  logic              start_ok;
  logic              accept;
  logic              first;
  logic              enter_done;

  assign start_ok   = (state == IDLE) && start && (frame_len != '0);
  assign accept     = (state == WAIT) && sample_valid;
  assign first      = (cnt_r == '0);
  assign cnt_inc    = cnt_r + LEN_W'(1);
  assign enter_done = (state_nxt == DONE) && (state != DONE);

  assign sample_ready = (state == WAIT);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  // The held sample is always operand a; operand b follows whichever bound is being tested.
  assign cmp_b = (state == CMP_MIN) ? min_r : max_r;

  comparator u_cmp (
    .a  (hold_r),
    .b  (cmp_b),
    .gt (cmp_gt),
    .lt (cmp_lt),
    .eq (cmp_eq)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = WAIT;
      end
      WAIT: begin
        if (sample_valid) begin
          if (!first)                              state_nxt = CMP_MAX;
          else if (frame_complete(cnt_inc, len_r)) state_nxt = DONE;
          else                                     state_nxt = WAIT;
        end
      end
      CMP_MAX: state_nxt = CMP_MIN;
      CMP_MIN: state_nxt = frame_complete(cnt_r, len_r) ? DONE : WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next working values are formed here so the result registers can capture
  // the final compare outcome on the same edge that enters DONE.
  always_comb begin
    max_nxt = max_r;
    min_nxt = min_r;
    if (accept && first) begin
      max_nxt = sample_in;
      min_nxt = sample_in;
    end
    if ((state == CMP_MAX) && cmp_gt && !cmp_eq) max_nxt = hold_r;
    if ((state == CMP_MIN) && cmp_lt && !cmp_eq) min_nxt = hold_r;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_r  <= '0;
      cnt_r  <= '0;
      hold_r <= '0;
    end else if (start_ok) begin
      len_r <= frame_len;
      cnt_r <= '0;
    end else if (accept) begin
      hold_r <= sample_in;
      cnt_r  <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      max_r <= '0;
      min_r <= '0;
    end else begin
      max_r <= max_nxt;
      min_r <= min_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      max_out <= '0;
      min_out <= '0;
    end else if (enter_done) begin
      max_out <= max_nxt;
      min_out <= min_nxt;
    end
  end

endmodule
